// File: rtl/usb_pkg.sv
// usb_pkg: shared constants, FSM state encoding and transaction payload for usb_sched.
package usb_pkg;

  localparam int unsigned USB_REQ_NUM      = 4;
  localparam int unsigned USB_IDX_W        = 2;
  localparam int unsigned USB_RAM_REGION_W = 10;
  localparam int unsigned USB_BTYPE_W      = 4;
  localparam int unsigned USB_CMD_W        = 32;
  localparam int unsigned USB_STAT_W       = 32;
  localparam int unsigned USB_TIMER_W      = 20;
  localparam int unsigned USB_RAM_INIT_W   = USB_IDX_W + USB_RAM_REGION_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_SWAIT = 3'd2,
    ST_RWAIT = 3'd3,
    ST_ACKX  = 3'd4,
    ST_READ  = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAIL  = 3'd7
  } usb_sched_state_e;

  // Transaction latched at grant time and held until the grant drops.
  typedef struct packed {
    logic [USB_IDX_W-1:0]   idx;
    logic [USB_BTYPE_W-1:0] btype;
    logic [USB_CMD_W-1:0]   cmd;
  } usb_txn_t;

  function automatic logic [USB_IDX_W-1:0] usb_onehot_idx(input logic [USB_REQ_NUM-1:0] oh);
    logic [USB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < USB_REQ_NUM; i++) begin
      if (oh[i]) idx = USB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/usb_sched_rr.sv
// usb_sched_rr: combinational round-robin pick of the first request at or after ptr.
module usb_sched_rr
  import usb_pkg::*;
(
  input  logic [USB_REQ_NUM-1:0] req,
  input  logic [USB_IDX_W-1:0]   ptr,
  output logic [USB_REQ_NUM-1:0] pick_c,
  output logic                   valid_c
);

  logic [USB_IDX_W-1:0] w_idx;

  // Scan ptr, ptr+1, ... with natural wrap of the index width.
  always_comb begin
    pick_c  = '0;
    valid_c = 1'b0;
    w_idx   = ptr;
    for (int k = 0; k < USB_REQ_NUM; k++) begin
      w_idx = USB_IDX_W'(ptr + USB_IDX_W'(k));
      if (!valid_c && req[w_idx]) begin
        pick_c[w_idx] = 1'b1;
        valid_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_sched.sv
// usb_sched: round-robin transaction scheduler sharing the usb link between four requesters.
// Define USB_SCHED_RETRY_EN to retry a timed-out response up to RETRY_MAX extra sends.
module usb_sched
  import usb_pkg::*;
#(
  parameter logic [USB_TIMER_W-1:0] TIMEOUT = 20'd500000
`ifdef USB_SCHED_RETRY_EN
  , parameter int unsigned RETRY_MAX = 2
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [USB_REQ_NUM-1:0]             req,
  input  logic [USB_REQ_NUM*USB_BTYPE_W-1:0] req_btype,
  input  logic [USB_REQ_NUM*USB_CMD_W-1:0]   req_cmd,
  output logic [USB_REQ_NUM-1:0]             grant,
  output logic [USB_REQ_NUM-1:0]             done,
  output logic [USB_REQ_NUM-1:0]             err,
  output logic [USB_STAT_W-1:0]              stat,
  output logic                               fs_send,
  output logic [USB_BTYPE_W-1:0]             send_btype,
  output logic [USB_CMD_W-1:0]               cache_cmd,
  input  logic                               fd_send,
  input  logic                               fs_read,
  input  logic [USB_BTYPE_W-1:0]             read_btype,
  output logic [USB_RAM_INIT_W-1:0]          read_ram_init,
  output logic                               fd_read,
  input  logic [USB_STAT_W-1:0]              cache_stat
);

`ifdef USB_SCHED_RETRY_EN
  localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 2);
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
`endif

  usb_sched_state_e       r_state;
  usb_sched_state_e       w_state_nxt;
  logic [USB_IDX_W-1:0]   r_ptr;
  logic [USB_IDX_W-1:0]   w_ptr_nxt;
  logic [USB_TIMER_W-1:0] r_timer;
  logic [USB_TIMER_W-1:0] w_timer_nxt;
  logic [USB_TIMER_W-1:0] w_timer_inc;
  logic                   w_timeout;
  usb_txn_t               r_txn;
  usb_txn_t               w_txn_nxt;
  usb_txn_t               w_pick_txn;
  logic [USB_REQ_NUM-1:0] r_grant;
  logic [USB_REQ_NUM-1:0] w_grant_nxt;
  logic [USB_REQ_NUM-1:0] r_done;
  logic [USB_REQ_NUM-1:0] w_done_nxt;
  logic [USB_REQ_NUM-1:0] r_err;
  logic [USB_REQ_NUM-1:0] w_err_nxt;
  logic [USB_STAT_W-1:0]  r_stat;
  logic [USB_STAT_W-1:0]  w_stat_nxt;
  logic                   r_fs_send;
  logic                   w_fs_send_nxt;
  logic                   r_fd_read;
  logic                   w_fd_read_nxt;
  logic [USB_REQ_NUM-1:0] w_rr_pick;
  logic                   w_rr_valid;

  usb_sched_rr u_rr (
    .req     (req),
    .ptr     (r_ptr),
    .pick_c  (w_rr_pick),
    .valid_c (w_rr_valid)
  );

  // Payload of the requester the arbiter would grant this cycle.
  always_comb begin
    w_pick_txn     = '0;
    w_pick_txn.idx = usb_onehot_idx(w_rr_pick);
    for (int i = 0; i < USB_REQ_NUM; i++) begin
      if (w_rr_pick[i]) begin
        w_pick_txn.btype = req_btype[i*USB_BTYPE_W +: USB_BTYPE_W];
        w_pick_txn.cmd   = req_cmd[i*USB_CMD_W +: USB_CMD_W];
      end
    end
  end

  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + USB_TIMER_W'(1);
  assign w_timeout   = (r_timer >= TIMEOUT - USB_TIMER_W'(1));

  // Next state plus next value of every registered output.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_timer_nxt   = r_timer;
    w_txn_nxt     = r_txn;
    w_grant_nxt   = r_grant;
    w_done_nxt    = '0;
    w_err_nxt     = '0;
    w_stat_nxt    = r_stat;
    w_fs_send_nxt = 1'b0;
    w_fd_read_nxt = 1'b0;
`ifdef USB_SCHED_RETRY_EN
    w_retry_nxt   = r_retry;
`endif
    unique case (r_state)
      ST_IDLE: begin
        // A stray response is acked and dropped before any new grant.
        if (fs_read) begin
          w_fd_read_nxt = 1'b1;
        end else if (w_rr_valid) begin
          w_txn_nxt     = w_pick_txn;
          w_grant_nxt   = w_rr_pick;
          w_fs_send_nxt = 1'b1;
          w_state_nxt   = ST_SEND;
`ifdef USB_SCHED_RETRY_EN
          w_retry_nxt   = '0;
`endif
        end
      end
      ST_SEND: begin
        w_fd_read_nxt = fs_read;
        w_fs_send_nxt = 1'b1;
        if (!fs_read && fd_send) begin
          w_fs_send_nxt = 1'b0;
          w_state_nxt   = ST_SWAIT;
        end
      end
      ST_SWAIT: begin
        w_fd_read_nxt = fs_read;
        if (!fs_read && !fd_send) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        w_timer_nxt = w_timer_inc;
        // A response arriving on the expiry cycle still takes priority.
        if (fs_read) begin
          w_fd_read_nxt = 1'b1;
          if (read_btype == r_txn.btype) begin
            w_stat_nxt  = cache_stat;
            w_state_nxt = ST_READ;
          end else begin
            w_state_nxt = ST_ACKX;
          end
        end else if (w_timeout) begin
`ifdef USB_SCHED_RETRY_EN
          if (r_retry < RETRY_W'(RETRY_MAX)) begin
            w_retry_nxt   = r_retry + RETRY_W'(1);
            w_fs_send_nxt = 1'b1;
            w_state_nxt   = ST_SEND;
          end else begin
            w_err_nxt   = r_grant;
            w_state_nxt = ST_FAIL;
          end
`else
          w_err_nxt   = r_grant;
          w_state_nxt = ST_FAIL;
`endif
        end
      end
      ST_ACKX: begin
        w_timer_nxt = w_timer_inc;
        if (fs_read) begin
          w_fd_read_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RWAIT;
        end
      end
      ST_READ: begin
        if (fs_read) begin
          w_fd_read_nxt = 1'b1;
        end else begin
          w_done_nxt  = r_grant;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE, ST_FAIL: begin
        w_grant_nxt = '0;
        w_ptr_nxt   = USB_IDX_W'(r_txn.idx + USB_IDX_W'(1));
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_timer   <= '0;
      r_txn     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_stat    <= '0;
      r_fs_send <= 1'b0;
      r_fd_read <= 1'b0;
`ifdef USB_SCHED_RETRY_EN
      r_retry   <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_txn     <= w_txn_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_stat    <= w_stat_nxt;
      r_fs_send <= w_fs_send_nxt;
      r_fd_read <= w_fd_read_nxt;
`ifdef USB_SCHED_RETRY_EN
      r_retry   <= w_retry_nxt;
`endif
    end
  end

  assign grant         = r_grant;
  assign done          = r_done;
  assign err           = r_err;
  assign stat          = r_stat;
  assign fs_send       = r_fs_send;
  assign fd_read       = r_fd_read;
  assign send_btype    = r_txn.btype;
  assign cache_cmd     = r_txn.cmd;
  assign read_ram_init = {r_txn.idx, USB_RAM_REGION_W'(0)};

endmodule
